i2c_calc_target: RTL and testbench

- I2C target (slave) front-end that sits directly upstream of the calculator core in the TinyTapeout top.
- Receives operands and the operation code over I2C into a small register file and drives them to the calculator.
- Issues a one-cycle go pulse when the operation register is written.
- Returns the calculator's 64-bit result to the I2C controller on reads.

---
 rtl/i2c_calc_target.sv | 250 +++++++++++++++++++++++++
 tb/tb_i2c_calc_target.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_calc_target.sv
// I2C target front-end for the calculator core: operand/opcode register file, go pulse and
// coherent 64-bit result readback. Define I2C_GLITCH_FILTER_EN for 3-sample majority filtering.
module i2c_calc_target #(
    parameter logic [6:0]  I2C_ADDR = 7'h2A,
    parameter int unsigned PTR_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [31:0] first_input_number,
    output logic [31:0] second_input_number,
    output logic [1:0]  operation,
    output logic        go,
    input  logic [63:0] result
);
    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWrByte, StWrAck, StRdByte, StRdAck, StIgnore
    } state_e;

    // Lines idle high, so conditioning flops reset to 1 to avoid false edges out of reset.
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_s, sda_s, scl_prev_q, sda_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_filt_q <= (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                          (scl_hist_q[0] & scl_hist_q[1]);
            sda_filt_q <= (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                          (sda_hist_q[0] & sda_hist_q[1]);
        end
    end

    assign scl_s = scl_filt_q;
    assign sda_s = sda_filt_q;
`else
    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         shift_q, shift_d, tx_q, tx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [63:0]        shadow_q, shadow_d;
    logic               oe_q, oe_d, ack_seen_q, ack_seen_d, nack_q, nack_d, rw_q, rw_d;
    logic               go_pend_q, go_pend_d, go_q, go_d;
    logic [7:0]         byte_in, rd_byte, ptr_ext;

    assign byte_in = {shift_q[6:0], sda_s};
    assign ptr_ext = 8'(ptr_q);

    always_comb begin
        rd_byte = 8'h00;
        if (ptr_ext < 8'h04)             rd_byte = a_q[{~ptr_ext[1:0], 3'b000} +: 8];
        else if (ptr_ext < 8'h08)        rd_byte = b_q[{~ptr_ext[1:0], 3'b000} +: 8];
        else if (ptr_ext == 8'h08)       rd_byte = {6'b0, op_q};
        else if (ptr_ext[7:3] == 5'h02)  rd_byte = shadow_q[{~ptr_ext[2:0], 3'b000} +: 8];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        shadow_d   = shadow_q;
        oe_d       = oe_q;
        ack_seen_d = ack_seen_q;
        nack_d     = nack_q;
        rw_d       = rw_q;
        go_pend_d  = 1'b0;
        go_d       = go_pend_q;
        if (start_det) begin
            state_d = StAddr;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = StIdle;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StPtr, StWrByte: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            ack_seen_d = 1'b0;
                            if (state_q == StAddr) begin
                                rw_d    = sda_s;
                                state_d = (shift_q[6:0] == I2C_ADDR) ? StAddrAck : StIgnore;
                            end else if (state_q == StPtr) begin
                                ptr_d   = byte_in[PTR_W-1:0];
                                state_d = StPtrAck;
                            end else begin
                                if (ptr_ext < 8'h04) a_d[{~ptr_ext[1:0], 3'b000} +: 8] = byte_in;
                                else if (ptr_ext < 8'h08) b_d[{~ptr_ext[1:0], 3'b000} +: 8] = byte_in;
                                else if (ptr_ext == 8'h08) begin
                                    op_d      = byte_in[1:0];
                                    go_pend_d = 1'b1;
                                end
                                ptr_d   = ptr_q + PTR_W'(1);
                                state_d = StWrAck;
                            end
                        end
                    end
                end
                StAddrAck, StPtrAck, StWrAck: begin
                    if (scl_rise) begin
                        ack_seen_d = 1'b1;
                        // Snapshot so a multi-byte read sees one coherent result.
                        if (state_q == StAddrAck && rw_q) shadow_d = result;
                    end else if (scl_fall) begin
                        if (!ack_seen_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d  = 1'b0;
                            cnt_d = 4'd0;
                            if (state_q == StAddrAck && rw_q) begin
                                state_d = StRdByte;
                                tx_d    = rd_byte;
                                oe_d    = ~rd_byte[7];
                            end else if (state_q == StAddrAck) begin
                                state_d = StPtr;
                            end else begin
                                state_d = StWrByte;
                            end
                        end
                    end
                end
                StRdByte: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d       = 1'b0;
                            ptr_d      = ptr_q + PTR_W'(1);
                            ack_seen_d = 1'b0;
                            state_d    = StRdAck;
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                            oe_d = ~tx_q[6];
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        ack_seen_d = 1'b1;
                        nack_d     = sda_s;
                    end else if (scl_fall && ack_seen_q) begin
                        if (nack_q) begin
                            state_d = StIgnore;
                        end else begin
                            state_d = StRdByte;
                            cnt_d   = 4'd0;
                            tx_d    = rd_byte;
                            oe_d    = ~rd_byte[7];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            ptr_q      <= '0;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            op_q       <= 2'b00;
            shadow_q   <= 64'h0;
            oe_q       <= 1'b0;
            ack_seen_q <= 1'b0;
            nack_q     <= 1'b0;
            rw_q       <= 1'b0;
            go_pend_q  <= 1'b0;
            go_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            shadow_q   <= shadow_d;
            oe_q       <= oe_d;
            ack_seen_q <= ack_seen_d;
            nack_q     <= nack_d;
            rw_q       <= rw_d;
            go_pend_q  <= go_pend_d;
            go_q       <= go_d;
        end
    end

    assign sda_oe              = oe_q;
    assign first_input_number  = a_q;
    assign second_input_number = b_q;
    assign operation           = op_q;
    assign go                  = go_q;
endmodule

// File: tb/tb_i2c_calc_target.sv
// Scoreboard bench for i2c_calc_target: bit-banged I2C controller, byte-array reference model.
`timescale 1ns/1ps
module tb_i2c_calc_target;
    localparam int Q = 80;  // quarter SCL period in ns (SCL = 32 clk)

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } go_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line, sda_oe, go;
    logic [31:0] a_o, b_o;
    logic [1:0]  op_o;
    logic [63:0] result_drv = 64'h0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_calc_target dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .scl_in              (scl),
        .sda_in              (sda_line),
        .sda_oe              (sda_oe),
        .first_input_number  (a_o),
        .second_input_number (b_o),
        .operation           (op_o),
        .go                  (go),
        .result              (result_drv)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int oe_cycles = 0;
    go_t        go_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] rd_obs_q[$];
    logic [7:0] wdata[$];

    // Reference model: byte-addressed register space plus result snapshot.
    logic [7:0]  mregs[32];
    int          mptr;
    logic [63:0] msnap;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic void m_reset();
        foreach (mregs[i]) mregs[i] = 8'h00;
        mptr  = 0;
        msnap = 64'h0;
    endfunction

    function automatic logic [31:0] m_a();
        return {mregs[0], mregs[1], mregs[2], mregs[3]};
    endfunction

    function automatic logic [31:0] m_b();
        return {mregs[4], mregs[5], mregs[6], mregs[7]};
    endfunction

    function automatic void m_write(input logic [7:0] d);
        go_t e;
        if (mptr < 8) begin
            mregs[mptr] = d;
        end else if (mptr == 8) begin
            mregs[8] = {6'b0, d[1:0]};
            e.a  = m_a();
            e.b  = m_b();
            e.op = d[1:0];
            go_q.push_back(e);
        end
        mptr = (mptr + 1) % 32;
    endfunction

    function automatic logic [7:0] m_read();
        logic [7:0] r;
        if (mptr <= 8) r = mregs[mptr];
        else if (mptr >= 16 && mptr <= 23) r = 8'(msnap >> (8 * (23 - mptr)));
        else r = 8'h00;
        mptr = (mptr + 1) % 32;
        return r;
    endfunction

    always @(posedge clk) if (sda_oe === 1'b1) oe_cycles++;

    // Monitors: compare DUT outputs against the expectation queues.
    always @(negedge clk) begin : mon_go
        go_t e;
        if (rst_n && go !== 1'b0) begin
            if (go_q.size() == 0) begin
                chk("go_unexpected", 1, 0);
            end else begin
                e = go_q.pop_front();
                chk("go_a", a_o, e.a);
                chk("go_b", b_o, e.b);
                chk("go_op", op_o, e.op);
            end
        end
    end

    always @(negedge clk) begin : mon_rd
        logic [7:0] o;
        if (rd_obs_q.size() > 0) begin
            o = rd_obs_q.pop_front();
            if (rd_exp_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_byte", o, rd_exp_q.pop_front());
        end
    end

    task automatic bit_xfer(input logic b, output logic s);
        sda_m = b;
        #Q scl = 1'b1;
        #Q s = sda_line;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic do_start();
        sda_m = 1'b1;
        #Q scl = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        #Q scl = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        logic [7:0] r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            r[i] = s;
        end
        bit_xfer(~ack, s);
        d = r;
    endtask

    task automatic wr_txn(input logic [4:0] ptr);
        logic ack;
        do_start();
        write_byte(8'h54, ack);
        chk("wr_addr_ack", ack, 1);
        write_byte({3'b0, ptr}, ack);
        chk("wr_ptr_ack", ack, 1);
        mptr = int'(ptr);
        foreach (wdata[i]) begin
            m_write(wdata[i]);
            write_byte(wdata[i], ack);
            chk("wr_data_ack", ack, 1);
        end
        do_stop();
        chk("reg_a", a_o, m_a());
        chk("reg_b", b_o, m_b());
        chk("reg_op", op_o, mregs[8][1:0]);
    endtask

    task automatic rd_txn(input logic [4:0] ptr, input int n, input int change_after,
                          input logic [63:0] new_res);
        logic ack;
        logic [7:0] d;
        do_start();
        write_byte(8'h54, ack);
        chk("rd_wr_addr_ack", ack, 1);
        write_byte({3'b0, ptr}, ack);
        chk("rd_ptr_ack", ack, 1);
        mptr = int'(ptr);
        do_start();
        write_byte(8'h55, ack);
        chk("rd_addr_ack", ack, 1);
        msnap = result_drv;
        for (int i = 0; i < n; i++) begin
            rd_exp_q.push_back(m_read());
            read_byte(i < n - 1, d);
            rd_obs_q.push_back(d);
            if (i == change_after) result_drv = new_res;
        end
        chk("rd_release", sda_oe, 0);
        do_stop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic ack;
        logic s;
        int   oe_before;
        logic [31:0] ra, rb;
        m_reset();

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_oe", sda_oe, 0);
        chk("rst_a", a_o, 0);
        chk("rst_b", b_o, 0);
        chk("rst_op", op_o, 0);
        chk("rst_go", go, 0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        chk("idle_no_oe", oe_cycles, 0);

        // Full write: A=16, B=4, op=0
        wdata = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
        wr_txn(5'h00);
        chk("full_a", a_o, 32'd16);
        chk("full_b", b_o, 32'd4);

        // Read result with a mid-read change: snapshot must hold
        result_drv = 64'h14;
        rd_txn(5'h10, 8, 1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Address mismatch
        oe_before = oe_cycles;
        do_start();
        write_byte(8'h56, ack);
        chk("mis_addr_nack", ack, 0);
        write_byte(8'hAA, ack);
        chk("mis_data_nack", ack, 0);
        do_stop();
        chk("mis_oe_quiet", oe_cycles - oe_before, 0);
        chk("mis_a", a_o, m_a());

        // Pointer wrap
        wdata = '{8'h77, 8'h01};
        wr_txn(5'h1F);
        chk("wrap_a_msb", a_o[31:24], 8'h01);

        // Randomized writes and reads
        for (int it = 0; it < 4; it++) begin
            ra = $urandom;
            rb = $urandom;
            wdata = '{ra[31:24], ra[23:16], ra[15:8], ra[7:0], rb[31:24], rb[23:16], rb[15:8],
                      rb[7:0], 8'($urandom)};
            wr_txn(5'h00);
            wdata = '{8'($urandom), 8'($urandom)};
            wr_txn(5'($urandom_range(0, 31)));
            result_drv = {$urandom, $urandom};
            rd_txn(5'($urandom_range(0, 31)), int'($urandom_range(1, 5)),
                   int'($urandom_range(0, 3)), {$urandom, $urandom});
        end

        // Abort with reset while the target drives SDA
        result_drv = 64'h0;
        do_start();
        write_byte(8'h54, ack);
        write_byte(8'h10, ack);
        do_start();
        write_byte(8'h55, ack);
        bit_xfer(1'b1, s);
        bit_xfer(1'b1, s);
        bit_xfer(1'b1, s);
        chk("abort_oe_driving", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_oe_reset", sda_oe, 0);
        scl = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(posedge clk);
        m_reset();
        chk("abort_a", a_o, 0);
        chk("abort_op", op_o, 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        rd_txn(5'h08, 2, -1, 64'h0);

        repeat (10) @(posedge clk);
        chk("go_all_seen", go_q.size(), 0);
        chk("rd_all_seen", rd_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
